// File: rtl/ree_rst_sequencer_if.sv
// rtl/ree_rst_sequencer_if.sv - boot-control request and REE core reset signals
interface ree_rst_sequencer_if;
   logic        ree_cpu_rst_n;
   logic [31:0] ree_cpu_rst_addr;
   logic        ree_bus_idle;
   logic        cpu_rst_b;
   logic [31:0] cpu_rst_vector;
   logic        cpu_halt_req;
   logic        rel_pulse;
   logic        drain_timeout;
   logic [1:0]  seq_state;

   modport master (
      output ree_cpu_rst_n, ree_cpu_rst_addr, ree_bus_idle,
      input  cpu_rst_b, cpu_rst_vector, cpu_halt_req, rel_pulse, drain_timeout, seq_state
   );

   modport slave (
      input  ree_cpu_rst_n, ree_cpu_rst_addr, ree_bus_idle,
      output cpu_rst_b, cpu_rst_vector, cpu_halt_req, rel_pulse, drain_timeout, seq_state
   );
endinterface

// File: rtl/ree_rst_sequencer.sv
// rtl/ree_rst_sequencer.sv - REE core reset sequencer: hold, settle, release, halt-and-drain
module ree_rst_sequencer #(
   parameter int unsigned HOLD_CYCLES   = 16,
   parameter int unsigned RELEASE_DELAY = 4,
   parameter int unsigned DRAIN_TIMEOUT = 256,
   parameter logic [31:0] RESET_VECTOR  = 32'h1007FFFF
) (
   input  logic                 hclk,
   input  logic                 hrst,
   ree_rst_sequencer_if.slave   bus
);
   localparam int unsigned MAX_HR  = (HOLD_CYCLES > RELEASE_DELAY) ? HOLD_CYCLES : RELEASE_DELAY;
   localparam int unsigned CNT_MAX = (MAX_HR > DRAIN_TIMEOUT) ? MAX_HR : DRAIN_TIMEOUT;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] HOLD_C    = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_DELAY - 1);
   localparam logic [CW-1:0] DRN_LAST  = CW'(DRAIN_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_PRE   = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   vector_q, vector_d;
   logic          timeout_q, timeout_d;
   logic          rst_b_q, rst_b_d;
   logic          halt_q, halt_d;
   logic          pulse_q, pulse_d;

   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         state_q   <= S_HOLD;
         cnt_q     <= '0;
         vector_q  <= RESET_VECTOR;
         timeout_q <= 1'b0;
         rst_b_q   <= 1'b0;
         halt_q    <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         vector_q  <= vector_d;
         timeout_q <= timeout_d;
         rst_b_q   <= rst_b_d;
         halt_q    <= halt_d;
         pulse_q   <= pulse_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      vector_d  = vector_q;
      timeout_d = timeout_q;
      case (state_q)
         S_HOLD: begin
            if (cnt_q == HOLD_C && bus.ree_cpu_rst_n) begin
               state_d  = S_PRE;
               vector_d = bus.ree_cpu_rst_addr;
            end else if (cnt_q != HOLD_C) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_PRE: begin
            if (!bus.ree_cpu_rst_n)      state_d = S_HOLD;
            else if (cnt_q == REL_LAST)  state_d = S_RUN;
            else                         cnt_d   = cnt_q + CNT_ONE;
         end
         S_RUN: begin
            if (!bus.ree_cpu_rst_n) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // Idle takes priority so a drain that finishes on the last cycle is not flagged.
            if (bus.ree_bus_idle) begin
               state_d = S_HOLD;
            end else if (cnt_q == DRN_LAST) begin
               state_d   = S_HOLD;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = S_HOLD;
      endcase
      if (state_d != state_q) cnt_d = '0;

      // Outputs are registered from the next state so they line up with seq_state.
      rst_b_d = (state_d == S_RUN) || (state_d == S_DRAIN);
      halt_d  = (state_d == S_DRAIN);
      pulse_d = (state_d == S_RUN) && (state_q != S_RUN);
   end

   assign bus.cpu_rst_b      = rst_b_q;
   assign bus.cpu_rst_vector = vector_q;
   assign bus.cpu_halt_req   = halt_q;
   assign bus.rel_pulse      = pulse_q;
   assign bus.drain_timeout  = timeout_q;
   assign bus.seq_state      = state_q;
endmodule

// File: tb/tb_ree_rst_sequencer.sv
// tb/tb_ree_rst_sequencer.sv - self-checking bench for ree_rst_sequencer
module tb_ree_rst_sequencer;
   localparam int          HOLD = 16;
   localparam int          RD   = 4;
   localparam int          DT   = 256;
   localparam logic [31:0] RV   = 32'h1007FFFF;

   logic hclk = 1'b0;
   logic hrst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   ree_rst_sequencer_if bus_if ();

   ree_rst_sequencer #(
      .HOLD_CYCLES(HOLD), .RELEASE_DELAY(RD), .DRAIN_TIMEOUT(DT), .RESET_VECTOR(RV)
   ) dut (
      .hclk(hclk),
      .hrst(hrst),
      .bus (bus_if)
   );

   always #5 hclk = ~hclk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: phase 0..3 plus the number of cycles already spent in that phase.
   int          m_ph;
   int          m_age;
   logic [31:0] m_vec;
   logic        m_to;

   always @(posedge hclk or posedge hrst) begin
      int nph;
      if (hrst) begin
         m_ph = 0; m_age = 0; m_vec = RV; m_to = 1'b0;
      end else begin
         nph = m_ph;
         case (m_ph)
            0: if (m_age >= HOLD && bus_if.ree_cpu_rst_n === 1'b1) begin
                  nph = 1; m_vec = bus_if.ree_cpu_rst_addr;
               end
            1: if (bus_if.ree_cpu_rst_n !== 1'b1) nph = 0;
               else if (m_age == RD - 1) nph = 2;
            2: if (bus_if.ree_cpu_rst_n !== 1'b1) nph = 3;
            default: if (bus_if.ree_bus_idle === 1'b1) nph = 0;
                     else if (m_age == DT - 1) begin nph = 0; m_to = 1'b1; end
         endcase
         m_age = (nph == m_ph) ? m_age + 1 : 0;
         m_ph  = nph;
      end
   end

   always @(negedge hclk) begin
      check("cpu_rst_b",      {31'd0, bus_if.cpu_rst_b},     {31'd0, m_ph >= 2});
      check("cpu_halt_req",   {31'd0, bus_if.cpu_halt_req},  {31'd0, m_ph == 3});
      check("rel_pulse",      {31'd0, bus_if.rel_pulse},     {31'd0, (m_ph == 2) && (m_age == 0)});
      check("drain_timeout",  {31'd0, bus_if.drain_timeout}, {31'd0, m_to});
      check("seq_state",      {30'd0, bus_if.seq_state},     32'(m_ph));
      check("cpu_rst_vector", bus_if.cpu_rst_vector,         m_vec);
   end

   task automatic edge_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge hclk); #2;
      end
   endtask

   task automatic wait_release(output int n);
      n = 0;
      while (bus_if.cpu_rst_b !== 1'b1 && n < 200) begin
         @(posedge hclk); #2; n++;
      end
   endtask

   task automatic wait_state(input logic [1:0] s);
      int n = 0;
      while (bus_if.seq_state !== s && n < 400) begin
         @(posedge hclk); #2; n++;
      end
      check("wait_state", {30'd0, bus_if.seq_state}, {30'd0, s});
   endtask

   initial begin
      int n;
      int cnt;
      bus_if.ree_cpu_rst_n    = 1'b1;
      bus_if.ree_cpu_rst_addr = 32'h2000_0100;
      bus_if.ree_bus_idle     = 1'b0;
      edge_n(2);
      check("reset_rst_b",  {31'd0, bus_if.cpu_rst_b}, 32'd0);
      check("reset_vector", bus_if.cpu_rst_vector, RV);
      check("reset_state",  {30'd0, bus_if.seq_state}, 32'd0);

      // Power-on release: 17 HOLD cycles (cnt 0..16) plus 4 PRE_RELEASE cycles.
      hrst = 1'b0;
      wait_release(n);
      check("first_release_edges", 32'(n), 32'd21);
      check("first_vector", bus_if.cpu_rst_vector, 32'h2000_0100);
      check("first_state",  {30'd0, bus_if.seq_state}, 32'd2);
      check("first_pulse",  {31'd0, bus_if.rel_pulse}, 32'd1);
      edge_n(1);
      check("pulse_one_cycle", {31'd0, bus_if.rel_pulse}, 32'd0);

      // Drain ended by bus idle after 10 DRAIN cycles.
      bus_if.ree_cpu_rst_n = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge hclk); #2;
         if (bus_if.cpu_halt_req === 1'b1) cnt++;
      end
      check("idle_drain_halt_cycles", 32'(cnt), 32'd10);
      bus_if.ree_bus_idle = 1'b1;
      edge_n(1);
      check("idle_drain_rst_b",   {31'd0, bus_if.cpu_rst_b},     32'd0);
      check("idle_drain_halt",    {31'd0, bus_if.cpu_halt_req},  32'd0);
      check("idle_drain_timeout", {31'd0, bus_if.drain_timeout}, 32'd0);
      bus_if.ree_bus_idle  = 1'b0;
      bus_if.ree_cpu_rst_n = 1'b1;
      wait_release(n);
      check("rerelease_edges", 32'(n), 32'd21);

      // Drain ended by timeout.
      bus_if.ree_cpu_rst_n = 1'b0;
      cnt = 0;
      n = 0;
      do begin
         @(posedge hclk); #2; n++;
         if (bus_if.cpu_halt_req === 1'b1) cnt++;
      end while (bus_if.cpu_rst_b === 1'b1 && n < 400);
      check("timeout_drain_cycles", 32'(cnt), 32'd256);
      check("timeout_state", {30'd0, bus_if.seq_state}, 32'd0);
      check("timeout_flag",  {31'd0, bus_if.drain_timeout}, 32'd1);
      bus_if.ree_cpu_rst_n = 1'b1;
      wait_release(n);
      check("timeout_release_edges", 32'(n), 32'd21);
      check("timeout_sticky", {31'd0, bus_if.drain_timeout}, 32'd1);

      // Abort in the second PRE_RELEASE cycle, then release with a new vector.
      bus_if.ree_bus_idle  = 1'b1;
      bus_if.ree_cpu_rst_n = 1'b0;
      wait_state(2'd0);
      bus_if.ree_bus_idle  = 1'b0;
      bus_if.ree_cpu_rst_n = 1'b1;
      wait_state(2'd1);
      edge_n(1);
      bus_if.ree_cpu_rst_n = 1'b0;
      edge_n(1);
      check("abort_state", {30'd0, bus_if.seq_state}, 32'd0);
      check("abort_rst_b", {31'd0, bus_if.cpu_rst_b}, 32'd0);
      bus_if.ree_cpu_rst_addr = 32'h2000_0200;
      bus_if.ree_cpu_rst_n    = 1'b1;
      wait_release(n);
      check("abort_release_edges", 32'(n), 32'd21);
      check("abort_vector", bus_if.cpu_rst_vector, 32'h2000_0200);

      // Asynchronous reset in DRAIN, mid-cycle.
      bus_if.ree_cpu_rst_n = 1'b0;
      edge_n(3);
      #1 hrst = 1'b1;
      #1;
      check("arst_drain_rst_b",  {31'd0, bus_if.cpu_rst_b},    32'd0);
      check("arst_drain_halt",   {31'd0, bus_if.cpu_halt_req}, 32'd0);
      check("arst_drain_vector", bus_if.cpu_rst_vector, RV);
      edge_n(1);
      bus_if.ree_cpu_rst_n = 1'b1;
      hrst = 1'b0;
      wait_release(n);
      check("arst_release_edges", 32'(n), 32'd21);

      // Asynchronous reset in RUN, mid-cycle.
      edge_n(2);
      #1 hrst = 1'b1;
      #1;
      check("arst_run_rst_b",  {31'd0, bus_if.cpu_rst_b},    32'd0);
      check("arst_run_halt",   {31'd0, bus_if.cpu_halt_req}, 32'd0);
      check("arst_run_vector", bus_if.cpu_rst_vector, RV);
      edge_n(1);

      // Request held low with a moving boot address: core stays in reset.
      bus_if.ree_cpu_rst_n = 1'b0;
      hrst = 1'b0;
      for (int i = 0; i < 60; i++) begin
         bus_if.ree_cpu_rst_addr = $urandom;
         edge_n(1);
      end
      check("held_rst_b",   {31'd0, bus_if.cpu_rst_b}, 32'd0);
      check("held_vector",  bus_if.cpu_rst_vector, RV);
      check("held_state",   {30'd0, bus_if.seq_state}, 32'd0);

      // Randomized traffic, checked every cycle against the reference.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) bus_if.ree_cpu_rst_n = ~bus_if.ree_cpu_rst_n;
         bus_if.ree_bus_idle     = ($urandom_range(0, 29) == 0);
         bus_if.ree_cpu_rst_addr = $urandom;
         hrst = ($urandom_range(0, 699) == 0);
         edge_n(1);
      end
      hrst = 1'b0;
      edge_n(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
